// File: rtl/alu_seq_responder.sv
// alu_seq_responder
// Execution end of the ALU request/response interface. A request (A, B,
// opcode, Cin) is taken over a valid/ready handshake, executed, and the
// 2*WIDTH-bit result is returned over a second valid/ready handshake.
// Single-cycle ops answer on the cycle after accept; unsigned multiply runs
// an iterative shift-add over WIDTH cycles.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-high
//   req_valid  request present
//   req_ready  responder can accept a request this cycle
//   A, B       operands (WIDTH bits)
//   opcode     operation select (3 bits)
//   Cin        carry/borrow in
//   rsp_valid  result available
//   rsp_ready  consumer takes the result
//   Out        result (2*WIDTH bits)
//   busy       multiply in progress
//   rsp_zero   (ALU_FLAGS_EN only) Out == 0
//   rsp_carry  (ALU_FLAGS_EN only) carry/borrow of ADD/SUB, else 0
//
// Optional feature macro: ALU_FLAGS_EN adds the rsp_zero/rsp_carry flags.
module alu_seq_responder #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [2:0]         opcode,
  input  logic               Cin,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*WIDTH-1:0] Out,
  output logic               busy
`ifdef ALU_FLAGS_EN
  ,
  output logic               rsp_zero,
  output logic               rsp_carry
`endif
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_LTU = 3'b111;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t               state, next_state;
  logic                 accept;
  logic [WIDTH-1:0]     a_reg, b_reg;
  logic [2*WIDTH-1:0]   acc, acc_next, partial;
  logic [SHW-1:0]       cnt;
  logic                 mul_last;
  logic [2*WIDTH-1:0]   out_reg, alu_res;
  logic [WIDTH:0]       add_w, sub_w;
`ifdef ALU_FLAGS_EN
  logic                 zero_reg, carry_reg;
`endif

  // Single-cycle ALU evaluated straight from the request inputs so the result
  // can be captured on the accept edge. SUB keeps its borrow in bit WIDTH and
  // sign-extends it through the upper half so the result reads as two's complement.
  always_comb begin
    add_w   = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};
    sub_w   = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, Cin};
    alu_res = '0;
    case (opcode)
      OP_ADD: alu_res = {{(WIDTH-1){1'b0}}, add_w};
      OP_SUB: alu_res = {{(WIDTH-1){sub_w[WIDTH]}}, sub_w};
      OP_MUL: alu_res = '0;
      OP_AND: alu_res = {{WIDTH{1'b0}}, A & B};
      OP_OR:  alu_res = {{WIDTH{1'b0}}, A | B};
      OP_XOR: alu_res = {{WIDTH{1'b0}}, A ^ B};
      OP_SLL: alu_res = {{WIDTH{1'b0}}, A} << B[SHW-1:0];
      OP_LTU: alu_res = {{(2*WIDTH-1){1'b0}}, (A < B)};
    endcase
  end

  // One shift-add step per cycle: bit cnt of A selects whether B shifted by
  // cnt is added into the accumulator. The final step's sum is the product.
  always_comb begin
    partial  = a_reg[cnt] ? ({{WIDTH{1'b0}}, b_reg} << cnt) : '0;
    acc_next = acc + partial;
    mul_last = (cnt == SHW'(WIDTH-1));
  end

  // Handshake and next-state logic. A result held in DONE can be consumed on
  // the same edge a new request is accepted, which keeps single-cycle ops
  // flowing at one per cycle.
  always_comb begin
    next_state = state;
    req_ready  = (state == IDLE) || ((state == DONE) && rsp_ready);
    accept     = req_valid && req_ready;
    rsp_valid  = (state == DONE);
    busy       = (state == MUL);
    case (state)
      IDLE: begin
        if (accept) next_state = (opcode == OP_MUL) ? MUL : DONE;
      end
      MUL: begin
        if (mul_last) next_state = DONE;
      end
      DONE: begin
        if (accept)         next_state = (opcode == OP_MUL) ? MUL : DONE;
        else if (rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register; reset aborts any multiply or pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Operand latching, multiply iteration and result capture. Single-cycle ops
  // register their result on the accept edge; a multiply latches its operands
  // and publishes the accumulator on its last iteration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      cnt       <= '0;
      out_reg   <= '0;
`ifdef ALU_FLAGS_EN
      zero_reg  <= 1'b0;
      carry_reg <= 1'b0;
`endif
    end else if (accept) begin
      if (opcode == OP_MUL) begin
        a_reg <= A;
        b_reg <= B;
        acc   <= '0;
        cnt   <= '0;
      end else begin
        out_reg   <= alu_res;
`ifdef ALU_FLAGS_EN
        zero_reg  <= (alu_res == '0);
        carry_reg <= ((opcode == OP_ADD) || (opcode == OP_SUB)) ? alu_res[WIDTH] : 1'b0;
`endif
      end
    end else if (state == MUL) begin
      acc <= acc_next;
      cnt <= cnt + SHW'(1);
      if (mul_last) begin
        out_reg   <= acc_next;
`ifdef ALU_FLAGS_EN
        zero_reg  <= (acc_next == '0);
        carry_reg <= 1'b0;
`endif
      end
    end
  end

  assign Out = out_reg;
`ifdef ALU_FLAGS_EN
  assign rsp_zero  = zero_reg;
  assign rsp_carry = carry_reg;
`endif

endmodule

// File: tb/tb_alu_seq_responder.sv
// tb_alu_seq_responder
// Directed and randomized requests against alu_seq_responder, checked against
// an arithmetic reference model (plain 64-bit math on the operands).
// With ALU_FLAGS_EN defined the rsp_zero/rsp_carry flags are checked as well.
module tb_alu_seq_responder;

  localparam int W = 32;

  logic           clk;
  logic           rst;
  logic           req_valid;
  logic           req_ready;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic [2:0]     opcode;
  logic           Cin;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [2*W-1:0] Out;
  logic           busy;
`ifdef ALU_FLAGS_EN
  logic           rsp_zero;
  logic           rsp_carry;
`endif

  int total = 0;
  int bad   = 0;

  alu_seq_responder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .A         (A),
    .B         (B),
    .opcode    (opcode),
    .Cin       (Cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .Out       (Out),
    .busy      (busy)
`ifdef ALU_FLAGS_EN
    ,
    .rsp_zero  (rsp_zero),
    .rsp_carry (rsp_carry)
`endif
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result: ordinary unsigned 64-bit arithmetic on the operands.
  // SUB wraps modulo 2^64, which yields the sign-extended borrow directly.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic cin);
    logic [63:0] a64, b64, c64;
    a64 = 64'(a);
    b64 = 64'(b);
    c64 = 64'(cin);
    case (op)
      3'd0:    return a64 + b64 + c64;
      3'd1:    return a64 - b64 - c64;
      3'd2:    return a64 * b64;
      3'd3:    return a64 & b64;
      3'd4:    return a64 | b64;
      3'd5:    return a64 ^ b64;
      3'd6:    return a64 << (b % 32);
      default: return (a < b) ? 64'd1 : 64'd0;
    endcase
  endfunction

  // Reference carry: the true carry of A+B+Cin, or the true borrow of A-B-Cin.
  function automatic logic modelCarry(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input logic cin);
    if (op == 3'd0) return (64'(a) + 64'(b) + 64'(cin)) > 64'hFFFF_FFFF;
    if (op == 3'd1) return 64'(a) < (64'(b) + 64'(cin));
    return 1'b0;
  endfunction

  // One comparison: counts it, and on a miss counts the failure and reports it.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request, wait for its response, and check latency, busy time,
  // result and flags. With hold > 0 the response is back-pressured for that
  // many cycles while Out must stay put and req_ready must stay low; rsp_ready
  // is then left low so the next call releases it on its own accept edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic cin, input int hold);
    logic [63:0] exp;
    int waits, n, busyN;
    exp       = model(op, a, b, cin);
    opcode    = op;
    A         = a;
    B         = b;
    Cin       = cin;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    #1;
    waits = 0;
    while (!req_ready && waits < 100) begin
      @(posedge clk); #1;
      waits++;
    end
    checkOutput("req_ready_before_accept", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rsp_ready = (hold == 0);
    n     = 1;
    busyN = 0;
    while (!rsp_valid && n < 200) begin
      if (busy) busyN++;
      @(posedge clk); #1;
      n++;
    end
    checkOutput("latency", 64'(n), (op == 3'd2) ? 64'(W + 1) : 64'd1);
    checkOutput("busy_cycles", 64'(busyN), (op == 3'd2) ? 64'(W) : 64'd0);
    checkOutput("busy_in_done", 64'(busy), 64'd0);
    checkOutput($sformatf("out_op%0d", op), Out, exp);
`ifdef ALU_FLAGS_EN
    checkOutput("rsp_zero", 64'(rsp_zero), 64'(exp == 64'd0));
    checkOutput("rsp_carry", 64'(rsp_carry), 64'(modelCarry(op, a, b, cin)));
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkOutput("hold_out", Out, exp);
      checkOutput("hold_valid", 64'(rsp_valid), 64'd1);
      checkOutput("hold_req_ready", 64'(req_ready), 64'd0);
    end
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    logic        rc;

    rst       = 1'b1;
    req_valid = 1'b0;
    A         = '0;
    B         = '0;
    opcode    = '0;
    Cin       = 1'b0;
    rsp_ready = 1'b1;
    #3;
    checkOutput("reset_req_ready", 64'(req_ready), 64'd1);
    checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("reset_out", Out, 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed cases
    applyStimulus(3'd0, 32'h4E, 32'h1E, 1'b0, 0);
    checkOutput("add_const", Out, 64'h6C);
    applyStimulus(3'd0, 32'h4E, 32'h1E, 1'b1, 0);
    checkOutput("add_cin_const", Out, 64'h6D);
    applyStimulus(3'd0, 32'hFFFF_FFFF, 32'h1, 1'b1, 0);
    applyStimulus(3'd1, 32'h46, 32'h3C, 1'b0, 0);
    checkOutput("sub_const", Out, 64'h0A);
    applyStimulus(3'd1, 32'h1E, 32'h4E, 1'b0, 0);
    checkOutput("sub_neg_const", Out, 64'hFFFF_FFFF_FFFF_FFD0);
    applyStimulus(3'd2, 32'h4E, 32'h1E, 1'b0, 0);
    checkOutput("mul_const", Out, 64'h924);
    applyStimulus(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
    checkOutput("mul_max_const", Out, 64'hFFFF_FFFE_0000_0001);
    applyStimulus(3'd2, 32'h0, 32'h1234, 1'b0, 0);
    applyStimulus(3'd6, 32'h8000_0001, 32'd4, 1'b0, 0);
    checkOutput("sll_const", Out, 64'h8_0000_0010);
    applyStimulus(3'd7, 32'h3C, 32'h46, 1'b0, 0);
    checkOutput("ltu_true", Out, 64'd1);
    applyStimulus(3'd7, 32'h46, 32'h3C, 1'b0, 0);
    checkOutput("ltu_false", Out, 64'd0);
    applyStimulus(3'd5, 32'h4E, 32'h1E, 1'b0, 0);
    checkOutput("xor_const", Out, 64'h50);

    // Back-pressure, then response handshake and new accept on the same edge
    applyStimulus(3'd3, 32'h4E, 32'h1E, 1'b0, 10);
    applyStimulus(3'd4, 32'h46, 32'h3C, 1'b0, 0);
    checkOutput("or_no_bubble", Out, 64'h7E);

    // Reset in cycle 10 of a multiply
    opcode    = 3'd2;
    A         = 32'h1234_5678;
    B         = 32'h9ABC_DEF0;
    Cin       = 1'b0;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    checkOutput("mul_busy_before_reset", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("abort_out", Out, 64'd0);
    checkOutput("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(3'd0, 32'd2, 32'd3, 1'b0, 0);
    checkOutput("add_after_reset", Out, 64'd5);

    // Randomized requests, occasionally back-pressured
    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(7, 0));
      ra  = $urandom;
      rb  = $urandom;
      rc  = 1'($urandom_range(1, 0));
      if ($urandom_range(3, 0) == 0) ra = rb;
      applyStimulus(rop, ra, rb, rc, ($urandom_range(4, 0) == 0) ? 3 : 0);
    end

    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("final_idle_valid", 64'(rsp_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
